score_scheduler: RTL and testbench
==================================

# score_scheduler

Arbitrates brick-collision and bonus events from up to four requesters (one per ball or power-up source) and applies them one at a time to a saturating score accumulator with a per-requester point value. It sits between the collision detectors and the score display/BCD path, and replaces direct single-source score incrementing once multi-ball play exists. Bursts are absorbed in per-requester pending counters and drained round-robin, one event per cycle.

## Interface
- N_REQ, 4, number of requesters (fixed at 4; pointer and select are 2 bits)
- PEND_W, 3, pending-counter width per requester (saturates at 2^PEND_W-1 = 7)
- MAX_SCORE, 999, score saturation ceiling (must be ≤ 1023)
- DEF_VALUE, 10, reset point value for every requester

- clk  in  1  system clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- i_event  in  N_REQ  per-requester event; each cycle high = one event
- i_clear  in  1  new-game clear, single-cycle pulse
- i_freeze  in  1  level; pauses draining (pause/game-over)
- i_cfg_we  in  1  point-value write strobe
- i_cfg_sel  in  2  requester index for the write
- i_cfg_value  in  7  new point value (0–127)
- o_score  out  10  current score
- o_grant  out  N_REQ  one-hot, high in the cycle a requester's event was applied
- o_busy  out  1  any pending counter nonzero
- o_drop  out  1  sticky: an event was lost to a saturated pending counter
- o_score_max  out  1  o_score == MAX_SCORE

## Operation
- State machine, registered: IDLE (no pending, not frozen), SERVE (pending, not frozen), HOLD (i_freeze high). IDLE→SERVE when any pending becomes nonzero; SERVE→IDLE when the last pending drains; any→HOLD while i_freeze=1; HOLD→SERVE/IDLE on release per pending state. i_clear forces IDLE (or HOLD if i_freeze=1).
- Pending counter per requester: +1 on i_event[i], −1 when granted; both in one cycle → unchanged. At 7 with event and no grant: count stays 7, o_drop set.
- Arbitration in SERVE only: round-robin over requesters with pending≠0, starting at pointer rr; winner w. After a grant rr = (w+1) mod 4. rr is unchanged without a grant. At most one grant per cycle.
- Score update on grant: score = min(score + value[w], MAX_SCORE), computed at 11 bits and then clamped. Once the score is at MAX_SCORE, grants still drain pending and pulse o_grant, and the score holds.
- Config: on i_cfg_we, value[i_cfg_sel] ← i_cfg_value at that edge. A grant at the same edge uses the old value. Value 0 is legal: the grant occurs and the score is unchanged.
- i_clear (highest priority below reset): score=0, all pending=0, o_drop=0, rr=0, o_grant=0. Events in the same cycle are discarded. Config values are retained.
- Reset: score=0, pending=0, rr=0, all values=DEF_VALUE, state IDLE; all outputs 0.

## Timing
- All outputs registered; o_busy and o_score_max derive from registered state.
- Event latency: i_event high in cycle 0 → pending=1 from cycle 1 → grant at edge ending cycle 1 → o_grant and new o_score visible in cycle 2.
- Drain throughput: 1 event/cycle. A burst of k pending events (all requesters) empties in k cycles when unfrozen.
- i_freeze sampled each edge: high in cycle n → no grant at the end of cycle n. Events still accumulate.
- o_grant is a single-cycle pulse per applied event. Back-to-back grants to the same requester are allowed when it is the only one pending.
- A cfg write in cycle n affects grants from cycle n+1 onward.

## Test plan
- Single event: reset, i_event=0001 for 1 cycle → o_grant=0001 and o_score=10 in cycle 2; o_busy high in cycle 1 only.
- Simultaneous burst: i_event=1111 for 1 cycle with rr=0 → grants 0001,0010,0100,1000 on consecutive cycles; score 40; rr=0 after.
- Saturation/drop: i_freeze=1, i_event=0010 for 9 cycles → pending[1]=7, o_drop=1; release freeze → exactly 7 grants, score 70.
- Config and clamp: write value[2]=127, then 8 events on requester 2 → score 127,254,…,889, then 999 on the 8th; o_score_max=1; a further event gives o_grant=0100 and the score stays 999.
- Clear mid-drain: 5 events pending on requester 0 (freeze held), release freeze and assert i_clear in the cycle after the 2nd grant → score 0, o_busy 0, o_drop 0, no further grants; value[0] unchanged.
- Event+grant collision: requester 3 holds pending=1 and i_event[3]=1 in its grant cycle → pending stays 1 and a second grant follows the next cycle.

Source files
------------

// File: rtl/score_scheduler_if.sv
// score_scheduler_if: event, config and score bundle between detectors and the score path
interface score_scheduler_if;
  logic [3:0] i_event;
  logic       i_clear;
  logic       i_freeze;
  logic       i_cfg_we;
  logic [1:0] i_cfg_sel;
  logic [6:0] i_cfg_value;
  logic [9:0] o_score;
  logic [3:0] o_grant;
  logic       o_busy;
  logic       o_drop;
  logic       o_score_max;
  modport master(
    output i_event, i_clear, i_freeze, i_cfg_we, i_cfg_sel, i_cfg_value,
    input  o_score, o_grant, o_busy, o_drop, o_score_max
  );
  modport slave(
    input  i_event, i_clear, i_freeze, i_cfg_we, i_cfg_sel, i_cfg_value,
    output o_score, o_grant, o_busy, o_drop, o_score_max
  );
endinterface

// File: rtl/score_scheduler.sv
// score_scheduler: round-robin drain of per-requester event counters into a saturating score
module score_scheduler #(
  parameter int N_REQ     = 4,
  parameter int PEND_W    = 3,
  parameter int MAX_SCORE = 999,
  parameter int DEF_VALUE = 10
) (
  input logic              clk,
  input logic              rst_n,
  score_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  logic [1:0]        state, state_nx;
  logic [PEND_W-1:0] pend [N_REQ];
  logic [PEND_W-1:0] pend_nx [N_REQ];
  logic [6:0]        value [N_REQ];
  logic [1:0]        rr, win;
  logic              found, grant, any_now, any_nx, drop_nx;
  logic [10:0]       sum;
  // first requester with pending events, scanning upward from the rr pointer
  always_comb begin
    win   = rr;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (pend[rr + 2'(k)] != '0) begin
        win   = rr + 2'(k);
        found = 1'b1;
      end
    end
  end
  assign grant = found && state == SERVE && !bus.i_freeze;
  assign sum   = {1'b0, bus.o_score} + {4'd0, value[win]};
  // pending counters: event and grant together cancel; a full counter drops the event
  always_comb begin
    drop_nx = bus.o_drop;
    any_nx  = 1'b0;
    any_now = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      pend_nx[i] = pend[i];
      if (bus.i_event[i] && !(grant && win == 2'(i))) begin
        if (pend[i] == PEND_MAX) drop_nx = 1'b1;
        else pend_nx[i] = pend[i] + 1'b1;
      end else if (!bus.i_event[i] && grant && win == 2'(i)) begin
        pend_nx[i] = pend[i] - 1'b1;
      end
      any_nx  = any_nx | (pend_nx[i] != '0);
      any_now = any_now | (pend[i] != '0);
    end
    state_nx = bus.i_freeze ? HOLD : (any_nx && !bus.i_clear) ? SERVE : IDLE;
  end
  assign bus.o_busy      = any_now;
  assign bus.o_score_max = bus.o_score == 10'(MAX_SCORE);
  // registered state, counters, config values and outputs; clear keeps the config values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr          <= '0;
      bus.o_score <= '0;
      bus.o_grant <= '0;
      bus.o_drop  <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        pend[i]  <= '0;
        value[i] <= 7'(DEF_VALUE);
      end
    end else begin
      state <= state_nx;
      if (bus.i_cfg_we) value[bus.i_cfg_sel] <= bus.i_cfg_value;
      if (bus.i_clear) begin
        rr          <= '0;
        bus.o_score <= '0;
        bus.o_grant <= '0;
        bus.o_drop  <= 1'b0;
        for (int i = 0; i < N_REQ; i++) pend[i] <= '0;
      end else begin
        pend        <= pend_nx;
        bus.o_drop  <= drop_nx;
        bus.o_grant <= grant ? 4'b0001 << win : 4'b0000;
        if (grant) begin
          rr          <= win + 2'd1;
          bus.o_score <= sum > 11'(MAX_SCORE) ? 10'(MAX_SCORE) : sum[9:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_score_scheduler.sv
// tb_score_scheduler: directed and random steps checked against a queue-count score model
module tb_score_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  score_scheduler_if bus();
  score_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  int m_pend [4];
  int m_val [4];
  int m_score, m_rr;
  bit m_drop, m_frz_prev;
  logic [3:0] m_grant;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    int busy;
    busy = 0;
    for (int i = 0; i < 4; i++) if (m_pend[i] != 0) busy = 1;
    chk("score", 16'(bus.o_score), 16'(m_score));
    chk("grant", 16'(bus.o_grant), 16'(m_grant));
    chk("busy", 16'(bus.o_busy), 16'(busy));
    chk("drop", 16'(bus.o_drop), 16'(m_drop));
    chk("score_max", 16'(bus.o_score_max), 16'(m_score == 999));
  endtask
  // one clock: an event is applied only if draining was already running before this edge
  task automatic model(input logic [3:0] ev, input logic clr, input logic frz,
                       input logic we, input logic [1:0] sel, input logic [6:0] val);
    int w;
    bit any;
    any = 0;
    for (int i = 0; i < 4; i++) if (m_pend[i] != 0) any = 1;
    m_grant = 4'b0000;
    if (clr) begin
      m_score = 0;
      m_rr = 0;
      m_drop = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
    end else begin
      if (!frz && !m_frz_prev && any) begin
        w = -1;
        for (int k = 0; k < 4 && w < 0; k++) if (m_pend[(m_rr + k) % 4] != 0) w = (m_rr + k) % 4;
        m_grant[w] = 1'b1;
        m_pend[w]--;
        m_score = (m_score + m_val[w] > 999) ? 999 : m_score + m_val[w];
        m_rr = (w + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
        if (ev[i]) begin
          if (m_pend[i] == 7) m_drop = 1;
          else m_pend[i]++;
        end
    end
    if (we) m_val[sel] = int'(val);
    m_frz_prev = frz;
  endtask
  task automatic step(input logic [3:0] ev, input logic clr, input logic frz,
                      input logic we, input logic [1:0] sel, input logic [6:0] val);
    bus.i_event = ev;
    bus.i_clear = clr;
    bus.i_freeze = frz;
    bus.i_cfg_we = we;
    bus.i_cfg_sel = sel;
    bus.i_cfg_value = val;
    @(posedge clk);
    model(ev, clr, frz, we, sel, val);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_event = '0;
    bus.i_clear = 1'b0;
    bus.i_freeze = 1'b0;
    bus.i_cfg_we = 1'b0;
    bus.i_cfg_sel = '0;
    bus.i_cfg_value = '0;
    @(posedge clk);
    m_score = 0;
    m_rr = 0;
    m_drop = 0;
    m_frz_prev = 0;
    m_grant = '0;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0;
      m_val[i] = 10;
    end
    #1;
    check_all();
    rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    // single event on requester 0
    step(4'b0001, 0, 0, 0, 2'd0, 7'd0);
    repeat (2) step(4'b0000, 0, 0, 0, 2'd0, 7'd0);
    // simultaneous burst drains in rr order
    step(4'b1111, 0, 0, 0, 2'd0, 7'd0);
    repeat (5) step(4'b0000, 0, 0, 0, 2'd0, 7'd0);
    // saturation and drop while frozen, then release
    repeat (9) step(4'b0010, 0, 1, 0, 2'd0, 7'd0);
    repeat (10) step(4'b0000, 0, 0, 0, 2'd0, 7'd0);
    // config value 127 on requester 2, clamp at 999
    step(4'b0000, 1, 0, 0, 2'd0, 7'd0);
    step(4'b0000, 0, 0, 1, 2'd2, 7'd127);
    repeat (9) step(4'b0100, 0, 0, 0, 2'd0, 7'd0);
    repeat (3) step(4'b0000, 0, 0, 0, 2'd0, 7'd0);
    // value 0 is legal: grant without score change; same-edge write uses old value
    step(4'b0000, 1, 0, 0, 2'd0, 7'd0);
    step(4'b1000, 0, 0, 1, 2'd3, 7'd0);
    step(4'b1000, 0, 0, 0, 2'd0, 7'd0);
    step(4'b0001, 0, 0, 1, 2'd3, 7'd5);
    repeat (3) step(4'b0000, 0, 0, 0, 2'd0, 7'd0);
    // clear mid-drain with five events pending on requester 0
    step(4'b0000, 1, 0, 0, 2'd0, 7'd0);
    repeat (5) step(4'b0001, 0, 1, 0, 2'd0, 7'd0);
    repeat (3) step(4'b0000, 0, 0, 0, 2'd0, 7'd0);
    step(4'b0001, 1, 0, 0, 2'd0, 7'd0);
    repeat (3) step(4'b0000, 0, 0, 0, 2'd0, 7'd0);
    step(4'b0001, 0, 0, 0, 2'd0, 7'd0);
    repeat (2) step(4'b0000, 0, 0, 0, 2'd0, 7'd0);
    // event and grant collide on requester 3
    step(4'b1000, 0, 0, 0, 2'd0, 7'd0);
    step(4'b1000, 0, 0, 0, 2'd0, 7'd0);
    repeat (3) step(4'b0000, 0, 0, 0, 2'd0, 7'd0);
    // random traffic with occasional clear, freeze and config writes
    for (int n = 0; n < 600; n++)
      step(4'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 2,
           $urandom_range(0, 11) == 0, 2'($urandom), 7'($urandom));
    do_reset();
    step(4'b0100, 0, 0, 0, 2'd0, 7'd0);
    repeat (2) step(4'b0000, 0, 0, 0, 2'd0, 7'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
